fifo_read_arbiter: RTL and testbench
====================================

// Module: fifo_read_arbiter
// PURPOSE
//  Shares the single read port of the synchronous FIFO among NREQ consumers.
//  Round-robin arbitration with burst-granular grants; drives the FIFO read-request (i_ready_m) input.
//  Routes returned read data to the granted consumer with a per-consumer valid.
//  Sits between the FIFO read controller/memory and the downstream consumers.
// PARAMETERS
//  NREQ     4   number of consumers (>=2)
//  DW       32  FIFO data width
//  BLW      4   width of burst-length input; burst length 1..2**BLW-1 beats
//  RD_LAT   1   cycles from FIFO read enable to valid read data (>=1)
//  STALL_TO 8   consecutive empty cycles inside a burst before the grant is released (>=1)
// PORTS
//  i_clk         in   1         clock
//  i_rst_n       in   1         asynchronous reset, active low
//  i_req         in   NREQ      per-consumer read request, level
//  i_burst_len   in   BLW       max beats per grant, sampled at grant; 0 treated as 1
//  i_fifo_empty  in   1         FIFO empty flag
//  i_fifo_rdata  in   DW        FIFO read data, valid RD_LAT cycles after a read
//  o_fifo_ready  out  1         read request to FIFO (its i_ready_m)
//  o_gnt         out  NREQ      one-hot current grant, 0 when idle
//  o_rvalid      out  NREQ      one-hot: o_rdata is valid for this consumer
//  o_rdata       out  DW        read data (registered copy of i_fifo_rdata)
//  o_busy        out  1         a grant is held or read data is still in flight
// BEHAVIOUR
//  Reset: state IDLE, o_gnt=0, o_fifo_ready=0, o_rvalid=0, o_rdata=0, o_busy=0, rr pointer=NREQ-1, counters=0.
//  Read event: rd = o_fifo_ready & ~i_fifo_empty (identical to FIFO ren).
//  FSM IDLE:
//   - If |i_req & ~i_fifo_empty: winner = first set i_req index scanning last_winner+1, +2, ... mod NREQ.
//   - Register o_gnt=onehot(winner), beats=0, blen=max(i_burst_len,1). Go BURST next cycle.
//   - No read occurs in the grant cycle: one-cycle arbitration latency.
//  FSM BURST:
//   - o_fifo_ready = i_req[gnt] (combinational from the registered grant).
//   - Each rd increments beats.
//   - Release (go IDLE, o_gnt=0, last_winner=gnt) on any of the following:
//     the rd that makes beats==blen, or i_req[gnt]==0, or the stall counter reaching STALL_TO.
//   - Stall counter: counts consecutive cycles with i_fifo_empty in BURST; clears on any rd.
//   - On release, the next grant is decided in IDLE at the earliest in the following cycle.
//   - Back-to-back bursts therefore have one idle gap cycle.
//   - Never two reads for one grant beyond blen; never a read while in IDLE.
//  Data return: RD_LAT-deep shift of (rd, gnt index).
//   - o_rvalid[idx] and o_rdata are registered, one cycle after the tap: total RD_LAT+1 cycles after rd.
//   - Data in flight still returns to the original consumer after release or a regrant.
//   - o_rdata holds its last value when o_rvalid==0.
//  o_busy = (state==BURST) | any in-flight bit in the return pipeline.
//  Width rules: beats is BLW bits; the stall counter is $clog2(STALL_TO+1) bits and saturates.
//  i_burst_len changes mid-burst are ignored.
//  Reset asserted mid-burst: all state and the in-flight pipeline are cleared immediately.
//  Data in flight is dropped; no o_rvalid after reset.
// TESTING
//  1. Single consumer: NREQ=4, req=0001, burst_len=3, FIFO holds 5 -> gnt=0001; 3 reads.
//     Data on rvalid[0] at rd+2; release; regrant after 1 gap; 2 more reads; then stall, released after 8 empty cycles.
//  2. Round-robin fairness: req=1111 constant, burst_len=1, FIFO deep -> grant order 0,1,2,3,0,... with one gap cycle each.
//  3. Early drop: consumer 2 granted with burst_len=8 and drops req after 2 reads.
//     -> exactly 2 reads, release next cycle, pointer advances to 3.
//  4. Empty mid-burst: FIFO empties after 1 of 4 beats and refills at stall cycle 5 -> grant held, reads resume, beats total 4.
//     Refill after 8 -> release at stall count 8.
//  5. In-flight routing: consumer 1 burst ends with rd at cycle t; consumer 2 granted at t+1.
//     -> rvalid[1] at t+2 with correct data, never rvalid[2] for that beat.
//  6. Reset mid-burst with a read in flight -> all outputs 0 same cycle; no rvalid after deassert; first grant goes to lowest requesting index.

Source files
------------

// File: rtl/fifo_read_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_read_arbiter
//   Shares the single read port of a synchronous FIFO among NREQ consumers.
//   Grants are round-robin and burst-granular: a winner keeps the read port
//   for up to i_burst_len beats, until it drops its request, or until the
//   FIFO has been empty for STALL_TO consecutive cycles. Each read is tagged
//   with the granted index, so its data returns to that consumer even if the
//   grant has moved on by the time the data arrives.
//
// Ports
//   i_clk, i_rst_n  clock and asynchronous active-low reset
//   i_req           per-consumer read request (level)
//   i_burst_len     max beats per grant, sampled at grant time (0 -> 1)
//   i_fifo_empty    FIFO empty flag
//   i_fifo_rdata    FIFO read data, valid RD_LAT cycles after a read
//   o_fifo_ready    read request to the FIFO (FIFO ren = ready & ~empty)
//   o_gnt           one-hot current grant, 0 when idle
//   o_rvalid        one-hot: o_rdata is valid for this consumer
//   o_rdata         registered copy of the returned read data
//   o_busy          grant held or read data still in flight
// ---------------------------------------------------------------------------
module fifo_read_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 32,
  parameter int BLW      = 4,
  parameter int RD_LAT   = 1,
  parameter int STALL_TO = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic [BLW-1:0]  i_burst_len,
  input  logic            i_fifo_empty,
  input  logic [DW-1:0]   i_fifo_rdata,
  output logic            o_fifo_ready,
  output logic [NREQ-1:0] o_gnt,
  output logic [NREQ-1:0] o_rvalid,
  output logic [DW-1:0]   o_rdata,
  output logic            o_busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(STALL_TO + 1);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [IW-1:0]   r_gnt_idx;
  logic [IW-1:0]   r_last;
  logic [BLW-1:0]  r_beats;
  logic [BLW-1:0]  r_blen;
  logic [SW-1:0]   r_stall;

  // Return pipeline: one (valid, consumer index) pair per cycle of read latency.
  logic            r_pipe_v   [RD_LAT];
  logic [IW-1:0]   r_pipe_idx [RD_LAT];
  logic [NREQ-1:0] r_rvalid;
  logic [DW-1:0]   r_rdata;

  logic            w_win_found;
  logic [IW-1:0]   w_win_idx;
  logic            w_req_gnt;
  logic            w_rd;
  logic [BLW-1:0]  w_beats_nx;
  logic [SW-1:0]   w_stall_nx;
  logic            w_release;
  logic            w_inflight;

  // Round-robin search starting just after the last winner.
  // NOTE: every signal assigned in a combinational block gets a default at the
  // top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_win_found && i_req[(int'(r_last) + k) % NREQ]) begin
        w_win_found = 1'b1;
        w_win_idx   = IW'((int'(r_last) + k) % NREQ);
      end
    end
  end

  assign w_req_gnt    = i_req[r_gnt_idx];
  assign o_fifo_ready = (r_state == S_BURST) && w_req_gnt;
  assign w_rd         = o_fifo_ready && !i_fifo_empty;
  assign w_beats_nx   = r_beats + 1'b1;
  assign w_stall_nx   = (r_stall == SW'(STALL_TO)) ? r_stall : r_stall + 1'b1;

  // A read implies the granted request is still up, so the release causes
  // are checked in this order without ambiguity.
  always_comb begin
    w_release = 1'b0;
    if (r_state == S_BURST) begin
      if (w_rd)              w_release = (w_beats_nx == r_blen);
      else if (!w_req_gnt)   w_release = 1'b1;
      else if (i_fifo_empty) w_release = (w_stall_nx == SW'(STALL_TO));
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_last    <= IW'(NREQ - 1);
      r_beats   <= '0;
      r_blen    <= '0;
      r_stall   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Grant cycle performs no read: one cycle of arbitration latency.
          if (w_win_found && !i_fifo_empty) begin
            r_state   <= S_BURST;
            r_gnt     <= NREQ'(1) << w_win_idx;
            r_gnt_idx <= w_win_idx;
            r_beats   <= '0;
            r_blen    <= (i_burst_len == '0) ? BLW'(1) : i_burst_len;
            r_stall   <= '0;
          end
        end
        S_BURST: begin
          if (w_release) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_last  <= r_gnt_idx;
            r_beats <= '0;
            r_stall <= '0;
          end else if (w_rd) begin
            r_beats <= w_beats_nx;
            r_stall <= '0;
          end else if (i_fifo_empty) begin
            r_stall <= w_stall_nx;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the return pipeline is reset explicitly because a reset must drop
  // every read still in flight; without it a stale valid could surface later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pipe_v[i]   <= 1'b0;
        r_pipe_idx[i] <= '0;
      end
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_pipe_v[0]   <= w_rd;
      r_pipe_idx[0] <= r_gnt_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_v[i]   <= r_pipe_v[i-1];
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end
      // The tap lines up with the data on i_fifo_rdata; o_rdata holds otherwise.
      r_rvalid <= '0;
      if (r_pipe_v[RD_LAT-1]) begin
        r_rvalid <= NREQ'(1) << r_pipe_idx[RD_LAT-1];
        r_rdata  <= i_fifo_rdata;
      end
    end
  end

  always_comb begin
    w_inflight = 1'b0;
    for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight | r_pipe_v[i];
  end

  assign o_gnt    = r_gnt;
  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
  assign o_busy   = (r_state == S_BURST) || w_inflight;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_read_arbiter
//   Directed bench for fifo_read_arbiter (NREQ=4, RD_LAT=1, STALL_TO=8).
//   A behavioural FIFO supplies data; every read it serves pushes the
//   expected consumer, data word and return cycle onto a scoreboard, and a
//   monitor pops and compares when that cycle comes around.
//   Within a cycle: inputs driven at posedge+1, FIFO flags at posedge+2,
//   outputs checked at posedge+3, reads and returns observed at negedge.
// ---------------------------------------------------------------------------
module tb_fifo_read_arbiter;

  localparam int NREQ     = 4;
  localparam int DW       = 32;
  localparam int BLW      = 4;
  localparam int RD_LAT   = 1;
  localparam int STALL_TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] i_req;
  logic [BLW-1:0]  i_burst_len;
  logic            i_fifo_empty;
  logic [DW-1:0]   i_fifo_rdata;
  logic            o_fifo_ready;
  logic [NREQ-1:0] o_gnt;
  logic [NREQ-1:0] o_rvalid;
  logic [DW-1:0]   o_rdata;
  logic            o_busy;

  fifo_read_arbiter #(
    .NREQ(NREQ), .DW(DW), .BLW(BLW), .RD_LAT(RD_LAT), .STALL_TO(STALL_TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_burst_len(i_burst_len),
    .i_fifo_empty(i_fifo_empty), .i_fifo_rdata(i_fifo_rdata),
    .o_fifo_ready(o_fifo_ready), .o_gnt(o_gnt), .o_rvalid(o_rvalid),
    .o_rdata(o_rdata), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int            owner;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] fq[$];
  int            exp_owner = 0;
  int            rd_count  = 0;
  int            base      = 0;
  logic [DW-1:0] last_data = '0;
  logic [DW-1:0] next_word = 32'h1000_0000;
  int            checks    = 0;
  int            errors    = 0;

  task automatic check(string tag, logic [63:0] observed, logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_words(int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(next_word);
      next_word = next_word + 32'h0000_0101;
    end
  endtask

  // Called at posedge+1; checks grant and ready at posedge+3.
  task automatic expect_state(string tag, logic [NREQ-1:0] gnt, logic rdy);
    #2;
    check(tag, 64'({o_gnt, o_fifo_ready}), 64'({gnt, rdy}));
  endtask

  task automatic clear_env();
    i_req = '0;
    sb.delete();
    fq.delete();
    last_data = '0;
  endtask

  task automatic do_reset();
    tick(1);
    rst_n = 1'b0;
    clear_env();
    tick(2);
    rst_n = 1'b1;
  endtask

  // Behavioural FIFO with one cycle of read latency.
  initial begin : fifo_model
    logic          rd;
    logic [DW-1:0] d;
    exp_t          e;
    i_fifo_empty = 1'b1;
    i_fifo_rdata = '0;
    forever begin
      @(negedge clk);
      rd = rst_n && o_fifo_ready && !i_fifo_empty;
      d  = DW'($urandom());
      if (rd) begin
        d       = fq.pop_front();
        e.owner = exp_owner;
        e.data  = d;
        e.due   = cyc + RD_LAT + 1;
        sb.push_back(e);
        rd_count++;
      end
      @(posedge clk);
      #2;
      i_fifo_rdata = d;
      i_fifo_empty = (fq.size() == 0);
    end
  end

  // Return monitor: routed data when due, otherwise no valid and held data.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        check("rvalid_route", 64'(o_rvalid), 64'(1) << sb[0].owner);
        check("rdata", 64'(o_rdata), 64'(sb[0].data));
        last_data = sb[0].data;
        void'(sb.pop_front());
      end else begin
        check("no_rvalid_hold", 64'({o_rvalid, o_rdata}), 64'({4'b0000, last_data}));
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    i_req       = '0;
    i_burst_len = '0;

    // Reset state
    tick(3);
    #2;
    check("reset_outputs", 64'({o_gnt, o_fifo_ready, o_rvalid, o_busy}), 64'(0));
    check("reset_rdata", 64'(o_rdata), 64'(0));
    tick(1);
    rst_n = 1'b1;

    // 1. Single consumer, burst 3, FIFO holds 5, then stall release
    i_req = 4'b0001; i_burst_len = 4'd3; exp_owner = 0; push_words(5); base = rd_count;
    expect_state("t1_arb_latency", 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin tick(); expect_state("t1_burst_a", 4'b0001, 1'b1); end
    tick(); expect_state("t1_gap", 4'b0000, 1'b0);
    check("t1_busy_inflight", 64'(o_busy), 64'(1));
    for (int i = 0; i < 2; i++) begin tick(); expect_state("t1_burst_b", 4'b0001, 1'b1); end
    for (int i = 0; i < STALL_TO; i++) begin tick(); expect_state("t1_stall_hold", 4'b0001, 1'b1); end
    tick(); expect_state("t1_stall_release", 4'b0000, 1'b0);
    check("t1_reads", 64'(rd_count - base), 64'(5));
    tick(); expect_state("t1_no_grant_empty", 4'b0000, 1'b0);
    tick(); i_req = '0;
    tick(2); #2;
    check("t1_idle_not_busy", 64'(o_busy), 64'(0));

    // 2. Round-robin fairness, burst 1
    do_reset();
    i_req = 4'b1111; i_burst_len = 4'd1; push_words(10); base = rd_count;
    expect_state("t2_idle", 4'b0000, 1'b0);
    for (int j = 0; j < 8; j++) begin
      tick(); exp_owner = j % NREQ;
      expect_state("t2_grant", NREQ'(1) << (j % NREQ), 1'b1);
      tick(); if (j == 7) i_req = '0;
      expect_state("t2_gap", 4'b0000, 1'b0);
    end
    check("t2_reads", 64'(rd_count - base), 64'(8));

    // 3. Early drop by consumer 2, mid-burst length change ignored
    tick(); i_req = 4'b0100; i_burst_len = 4'd8; exp_owner = 2; push_words(8); base = rd_count;
    expect_state("t3_idle", 4'b0000, 1'b0);
    tick(); i_burst_len = 4'd1; expect_state("t3_read1", 4'b0100, 1'b1);
    tick(); expect_state("t3_len_ignored", 4'b0100, 1'b1);
    tick(); i_req = 4'b0000; expect_state("t3_drop", 4'b0100, 1'b0);
    tick(); i_req = 4'b1100; i_burst_len = 4'd1; expect_state("t3_release", 4'b0000, 1'b0);
    check("t3_reads", 64'(rd_count - base), 64'(2));
    tick(); exp_owner = 3; expect_state("t3_ptr_adv", 4'b1000, 1'b1);
    tick(); i_req = '0; expect_state("t3_done", 4'b0000, 1'b0);

    // 4a. FIFO empties after 1 of 4 beats, refills after 5 empty cycles
    do_reset();
    i_req = 4'b0001; i_burst_len = 4'd4; exp_owner = 0; push_words(1); base = rd_count;
    expect_state("t4_idle", 4'b0000, 1'b0);
    tick(); expect_state("t4_beat1", 4'b0001, 1'b1);
    for (int i = 0; i < 5; i++) begin tick(); expect_state("t4_stall_hold", 4'b0001, 1'b1); end
    tick(); push_words(3); expect_state("t4_refill", 4'b0001, 1'b1);
    for (int i = 0; i < 2; i++) begin tick(); expect_state("t4_resume", 4'b0001, 1'b1); end
    tick(); expect_state("t4_release_len", 4'b0000, 1'b0);
    check("t4_reads", 64'(rd_count - base), 64'(4));

    // 4b. No refill: release exactly at stall count STALL_TO
    tick(); push_words(1); base = rd_count;
    expect_state("t4b_idle", 4'b0000, 1'b0);
    tick(); expect_state("t4b_beat1", 4'b0001, 1'b1);
    for (int i = 0; i < STALL_TO; i++) begin tick(); expect_state("t4b_stall_hold", 4'b0001, 1'b1); end
    tick(); i_req = '0; expect_state("t4b_stall_release", 4'b0000, 1'b0);
    check("t4b_reads", 64'(rd_count - base), 64'(1));

    // 5. In-flight beat of consumer 1 returns while consumer 2 holds grant
    tick(); i_req = 4'b0110; i_burst_len = 4'd2; exp_owner = 1; push_words(4); base = rd_count;
    expect_state("t5_idle", 4'b0000, 1'b0);
    tick(); expect_state("t5_c1_beat1", 4'b0010, 1'b1);
    tick(); expect_state("t5_c1_beat2", 4'b0010, 1'b1);
    tick(); expect_state("t5_gap", 4'b0000, 1'b0);
    tick(); exp_owner = 2; expect_state("t5_c2_grant", 4'b0100, 1'b1);
    check("t5_inflight_route", 64'(o_rvalid), 64'(4'b0010));
    tick(); expect_state("t5_c2_beat2", 4'b0100, 1'b1);
    tick(); i_req = '0; expect_state("t5_done", 4'b0000, 1'b0);
    check("t5_reads", 64'(rd_count - base), 64'(4));

    // 6. Reset mid-burst with a read in flight
    tick(); i_req = 4'b1010; i_burst_len = 4'd4; exp_owner = 3; push_words(6);
    expect_state("t6_idle", 4'b0000, 1'b0);
    tick(); expect_state("t6_grant3", 4'b1000, 1'b1);
    tick(); rst_n = 1'b0; sb.delete(); fq.delete(); last_data = '0;
    #2;
    check("t6_reset_async", 64'({o_gnt, o_fifo_ready, o_rvalid, o_busy}), 64'(0));
    check("t6_reset_rdata", 64'(o_rdata), 64'(0));
    tick(); #2;
    check("t6_reset_hold", 64'({o_gnt, o_fifo_ready, o_rvalid, o_busy}), 64'(0));
    tick(); rst_n = 1'b1; exp_owner = 1; push_words(2);
    expect_state("t6_post_reset_idle", 4'b0000, 1'b0);
    tick(); expect_state("t6_lowest_first", 4'b0010, 1'b1);
    tick(); i_req = '0; expect_state("t6_drop", 4'b0010, 1'b0);
    tick(4); #2;
    check("t6_final_busy", 64'(o_busy), 64'(0));
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
